result_collector: RTL

Writer side of the classifier result buffer. Takes the final layer's per-class scores as a serial stream of 32-bit signed partial sums and saturates each one to 16 bits signed. Packs NUM_CLASS scores into one 160-bit vector and commits it to the result buffer (`write_result_data` / `write_result_signal`) with a single-cycle write strobe. It then holds a result-valid flag for the controller until the result has been read.

---
 rtl/result_collector_pkg.sv | 28 ++
 rtl/result_collector_saturate.sv | 30 +++
 rtl/result_collector.sv | 129 ++++++++++++
 3 files changed

// File: rtl/result_collector_pkg.sv
// result_collector_pkg
// Shared types and constants for the classifier result collector.
//   state_e   : collector FSM states
//   NUM_CLASS : class scores packed per frame
//   IN_W      : width of an incoming signed partial sum
//   OUT_W     : width of one packed signed score
//   CNT_W     : lane counter width
//   SAT_MAX   : positive saturation value for OUT_W = 16
//   SAT_MIN   : negative saturation value for OUT_W = 16
package result_collector_pkg;

   localparam int unsigned NUM_CLASS = 10;
   localparam int unsigned IN_W      = 32;
   localparam int unsigned OUT_W     = 16;
   localparam int unsigned VEC_W     = NUM_CLASS * OUT_W;
   localparam int unsigned CNT_W     = 4;

   localparam logic [OUT_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [OUT_W-1:0] SAT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StWrite,
      StDone
   } state_e;

endpackage

// File: rtl/result_collector_saturate.sv
// score_saturate
// Combinational signed saturation from IN_W to OUT_W bits.
//   in_data  : signed input value
//   out_data : in_data clamped to the OUT_W signed range
module score_saturate #(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned OUT_W = 16
) (
   input  logic [IN_W-1:0]  in_data,
   output logic [OUT_W-1:0] out_data
);

   // The value fits when every bit from the OUT_W sign bit upward matches.
   logic [IN_W-OUT_W:0] upper;
   logic                fits;

   assign upper = in_data[IN_W-1:OUT_W-1];
   assign fits  = (&upper) | ~(|upper);

   always_comb begin
      if (fits) begin
         out_data = in_data[OUT_W-1:0];
      end else if (in_data[IN_W-1]) begin
         out_data = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         out_data = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/result_collector.sv
// result_collector
// Collects NUM_CLASS serial partial sums, saturates each to OUT_W bits, packs
// them and commits the vector to the result buffer with a one-cycle strobe.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin / restart frame collection
//   in_valid, in_data   : score stream (one beat per class, in lane order)
//   in_ready            : high while collecting
//   write_result_data   : packed scores, lane k at [16k+15:16k]
//   write_result_signal : one-cycle write strobe
//   result_valid        : result complete, held until result_ack
//   result_ack          : controller has read the result
//   busy                : collection or write in progress
module result_collector
   import result_collector_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             in_ready,
   output logic [VEC_W-1:0] write_result_data,
   output logic             write_result_signal,
   output logic             result_valid,
   input  logic             result_ack,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_CLASS - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [VEC_W-1:0]     vec_q;
   logic [NUM_CLASS-1:0] lane_we;
   logic                 clear;
   logic                 accept;
   logic [OUT_W-1:0]     sat_score;

   score_saturate #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_sat (
      .in_data  (in_data),
      .out_data (sat_score)
   );

   // All outputs decode from state or come straight from registers.
   assign in_ready            = (state_q == StCollect);
   assign write_result_signal = (state_q == StWrite);
   assign result_valid        = (state_q == StDone);
   assign busy                = (state_q == StCollect) || (state_q == StWrite);
   assign write_result_data   = vec_q;

   // A start in COLLECT aborts the frame, so a same-cycle beat is dropped.
   assign accept = in_ready && in_valid && !start;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clear   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCollect;
               cnt_d   = '0;
               clear   = 1'b1;
            end
         end
         StCollect: begin
            if (start) begin
               cnt_d = '0;
               clear = 1'b1;
            end else if (in_valid) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_LANE) begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            state_d = StDone;
         end
         StDone: begin
            if (start) begin
               state_d = StCollect;
               cnt_d   = '0;
               clear   = 1'b1;
            end else if (result_ack) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      lane_we = '0;
      for (int k = 0; k < int'(NUM_CLASS); k++) begin
         lane_we[k] = accept && (cnt_q == CNT_W'(k));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q <= '0;
      end else if (clear) begin
         vec_q <= '0;
      end else begin
         for (int k = 0; k < int'(NUM_CLASS); k++) begin
            if (lane_we[k]) begin
               vec_q[k*OUT_W +: OUT_W] <= sat_score;
            end
         end
      end
   end

endmodule
